// File: rtl/core_sequencer.sv
// Multi-cycle control sequencer: FETCH/DECODE/EXECUTE/MEM/WB with a sticky HALT.
// Emits fetch/data requests, PC/RF strobes, and counts retired instructions.
module core_sequencer (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    input  logic        imem_ack,
    output logic        ir_write,
    input  logic        is_load,
    input  logic        is_store,
    input  logic        is_branch,
    input  logic        is_jump,
    input  logic        is_system,
    input  logic        illegal,
    input  logic        reg_write_enable,
    input  logic        branch_taken,
    output logic        dmem_req,
    output logic        dmem_we,
    input  logic        dmem_ack,
    output logic        pc_write,
    output logic        pc_sel,
    output logic        rf_write,
    output logic [2:0]  state,
    output logic        halted,
    output logic [31:0] instret
);

    typedef enum logic [2:0] {
        FETCH   = 3'd0,
        DECODE  = 3'd1,
        EXECUTE = 3'd2,
        MEM     = 3'd3,
        WB      = 3'd4,
        HALT    = 3'd5
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] instret_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= FETCH;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                instret_q <= '0;
        else if (state_q == WB) instret_q <= instret_q + 32'd1;
    end

    // Unused encodings fall into the default arm and land in HALT.
    always_comb begin
        state_d = HALT;
        case (state_q)
            FETCH:   state_d = imem_ack ? DECODE : FETCH;
            DECODE:  state_d = (illegal || is_system || (is_load && is_store)) ? HALT : EXECUTE;
            EXECUTE: state_d = (is_load || is_store) ? MEM : WB;
            MEM:     state_d = dmem_ack ? WB : MEM;
            WB:      state_d = FETCH;
            HALT:    state_d = HALT;
            default: state_d = HALT;
        endcase
    end

    // Gating on rst kills requests in the same cycle reset is asserted.
    always_comb begin
        imem_req = 1'b0;
        ir_write = 1'b0;
        dmem_req = 1'b0;
        dmem_we  = 1'b0;
        pc_write = 1'b0;
        pc_sel   = 1'b0;
        rf_write = 1'b0;
        if (!rst) begin
            case (state_q)
                FETCH: begin
                    imem_req = 1'b1;
                    ir_write = imem_ack;
                end
                MEM: begin
                    dmem_req = 1'b1;
                    dmem_we  = is_store;
                end
                WB: begin
                    pc_write = 1'b1;
                    pc_sel   = is_jump | (is_branch & branch_taken);
                    rf_write = reg_write_enable & ~is_store & ~is_branch;
                end
                default: ;
            endcase
        end
    end

    assign state   = state_q;
    assign halted  = (state_q == HALT);
    assign instret = instret_q;

endmodule

// File: tb/tb_core_sequencer.sv
// Directed bench for core_sequencer: per-class instruction flows, waits, halt, wrap, reset.
`timescale 1ns/1ps
module tb_core_sequencer;

    logic        clk, rst;
    logic        imem_req, imem_ack, ir_write;
    logic        is_load, is_store, is_branch, is_jump, is_system, illegal, reg_write_enable;
    logic        branch_taken;
    logic        dmem_req, dmem_we, dmem_ack;
    logic        pc_write, pc_sel, rf_write;
    logic [2:0]  state;
    logic        halted;
    logic [31:0] instret;

    int checks = 0;
    int errors = 0;

    logic        wb_sel, wb_rf, mem_we;
    logic [31:0] exp_instret;
    int          exp_states [7] = '{1, 2, 3, 3, 3, 4, 0};

    core_sequencer dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_ack(imem_ack), .ir_write(ir_write),
        .is_load(is_load), .is_store(is_store), .is_branch(is_branch), .is_jump(is_jump),
        .is_system(is_system), .illegal(illegal), .reg_write_enable(reg_write_enable),
        .branch_taken(branch_taken),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
        .pc_write(pc_write), .pc_sel(pc_sel), .rf_write(rf_write),
        .state(state), .halted(halted), .instret(instret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_dec(input logic ld, input logic st, input logic br, input logic jp,
                           input logic sys, input logic ill, input logic rwe, input logic tk);
        is_load = ld; is_store = st; is_branch = br; is_jump = jp;
        is_system = sys; illegal = ill; reg_write_enable = rwe; branch_taken = tk;
    endtask

    // Runs one instruction from FETCH back to FETCH, capturing WB/MEM strobes.
    task automatic run_instr(input string tag, input int exp_cycles,
                             output logic sel, output logic rf, output logic we);
        int n;
        n = 0; sel = 1'b0; rf = 1'b0; we = 1'b0;
        do begin
            tick();
            n++;
            if (state == 3'd4) begin sel = pc_sel; rf = rf_write; end
            if (state == 3'd3) we = dmem_we;
        end while (state != 3'd0 && n < 20);
        check({tag, "_cycles"}, n, exp_cycles);
    endtask

    initial begin
        rst = 1'b1; imem_ack = 1'b0; dmem_ack = 1'b0;
        set_dec(0, 0, 0, 0, 0, 0, 0, 0);
        #2;
        check("rst_state", state, 0);
        check("rst_instret", instret, 0);
        check("rst_halted", halted, 0);
        check("rst_imem_req", imem_req, 0);
        tick();
        rst = 1'b0;
        #1;
        check("first_imem_req", imem_req, 1);

        // ADDI with immediate fetch ack, stepped by hand
        set_dec(0, 0, 0, 0, 0, 0, 1, 0);
        imem_ack = 1'b1; dmem_ack = 1'b1;
        #1;
        check("addi_ir_write", ir_write, 1);
        tick(); check("addi_s1", state, 1);
        tick(); check("addi_s2", state, 2);
        tick(); check("addi_s4", state, 4);
        check("addi_pc_write", pc_write, 1);
        check("addi_rf_write", rf_write, 1);
        check("addi_pc_sel", pc_sel, 0);
        check("addi_instret_wb", instret, 0);
        tick(); check("addi_s0", state, 0);
        check("addi_instret", instret, 1);
        run_instr("addi2", 4, wb_sel, wb_rf, mem_we);
        check("addi2_instret", instret, 2);

        // Fetch waits: ir_write follows imem_ack, FETCH holds
        imem_ack = 1'b0;
        #1; check("wait_ir_write", ir_write, 0);
        tick(); check("wait_s0a", state, 0);
        tick(); check("wait_s0b", state, 0);
        imem_ack = 1'b1;
        #1; check("wait_ir_write_ack", ir_write, 1);
        run_instr("addi3", 4, wb_sel, wb_rf, mem_we);
        exp_instret = 3;

        set_dec(1, 0, 0, 0, 0, 0, 1, 0);
        run_instr("load", 5, wb_sel, wb_rf, mem_we);
        check("load_rf", wb_rf, 1);
        check("load_we", mem_we, 0);
        exp_instret++;

        // Load with ack arriving on the third MEM cycle
        dmem_ack = 1'b0;
        for (int i = 0; i < 7; i++) begin
            tick();
            if (i == 4) begin dmem_ack = 1'b1; #1; end
            check($sformatf("ldw_s%0d", i), state, exp_states[i]);
            if (exp_states[i] == 3) begin
                check($sformatf("ldw_req%0d", i), dmem_req, 1);
                check($sformatf("ldw_we%0d", i), dmem_we, 0);
            end
            if (exp_states[i] == 4) check("ldw_rf", rf_write, 1);
        end
        exp_instret++;

        set_dec(0, 1, 0, 0, 0, 0, 1, 0);
        run_instr("store", 5, wb_sel, wb_rf, mem_we);
        check("store_we", mem_we, 1);
        check("store_rf", wb_rf, 0);
        exp_instret++;

        set_dec(0, 0, 1, 0, 0, 0, 1, 1);
        run_instr("br_taken", 4, wb_sel, wb_rf, mem_we);
        check("br_taken_sel", wb_sel, 1);
        check("br_taken_rf", wb_rf, 0);
        exp_instret++;

        set_dec(0, 0, 1, 0, 0, 0, 1, 0);
        run_instr("br_not", 4, wb_sel, wb_rf, mem_we);
        check("br_not_sel", wb_sel, 0);
        exp_instret++;

        set_dec(0, 0, 0, 1, 0, 0, 1, 0);
        run_instr("jump", 4, wb_sel, wb_rf, mem_we);
        check("jump_sel", wb_sel, 1);
        check("jump_rf", wb_rf, 1);
        exp_instret++;
        check("instret_count", instret, exp_instret);

        // Counter wrap
        force dut.instret_q = 32'hFFFF_FFFF;
        #1;
        release dut.instret_q;
        #1;
        check("wrap_preset", instret, 32'hFFFF_FFFF);
        set_dec(0, 0, 0, 0, 0, 0, 1, 0);
        run_instr("wrap_addi", 4, wb_sel, wb_rf, mem_we);
        check("wrap_instret", instret, 0);

        // Reset asserted while MEM is requesting
        set_dec(1, 0, 0, 0, 0, 0, 1, 0);
        dmem_ack = 1'b0;
        tick(); tick(); tick();
        check("mid_mem_state", state, 3);
        check("mid_mem_req", dmem_req, 1);
        #2; rst = 1'b1; #1;
        check("rst_mem_req", dmem_req, 0);
        check("rst_mem_state", state, 0);
        check("rst_mem_instret", instret, 0);
        tick();
        rst = 1'b0; dmem_ack = 1'b1;
        #1;
        check("rst_rel_imem_req", imem_req, 1);

        // Illegal instruction halts; further fetch acks are ignored
        set_dec(0, 0, 0, 0, 0, 1, 1, 0);
        tick(); check("ill_s1", state, 1);
        tick(); check("ill_halt", state, 5);
        check("ill_halted", halted, 1);
        check("ill_imem_req", imem_req, 0);
        check("ill_ir_write", ir_write, 0);
        check("ill_pc_write", pc_write, 0);
        tick(); tick(); tick();
        check("ill_stay", state, 5);
        check("ill_instret", instret, 0);

        // Load+store combo also halts from DECODE
        rst = 1'b1; #1; rst = 1'b0;
        set_dec(1, 1, 0, 0, 0, 0, 1, 0);
        tick(); tick();
        check("ldst_halt", state, 5);

        rst = 1'b1; #1; rst = 1'b0;
        set_dec(0, 0, 0, 0, 1, 0, 0, 0);
        tick(); tick();
        check("sys_halt", state, 5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/core_sequencer.md
CORE_SEQUENCER -- requirements
Module: core_sequencer

Interface
REQ-001 The block SHALL have one clock and an asynchronous active-high reset; all state changes SHALL occur on the rising edge of clk or on assertion of rst.
REQ-002 Port `clk` SHALL be an input, 1 bit wide: the core clock.
REQ-003 Port `rst` SHALL be an input, 1 bit wide: the asynchronous, active-high reset.
REQ-004 Port `imem_req` SHALL be an output, 1 bit wide: the instruction fetch request.
REQ-005 Port `imem_ack` SHALL be an input, 1 bit wide: the instruction word is valid this cycle.
REQ-006 Port `ir_write` SHALL be an output, 1 bit wide: it latches the instruction word into the IR.
REQ-007 Ports `is_load`, `is_store`, `is_branch`, `is_jump`, `is_system`, `illegal` and `reg_write_enable` SHALL be inputs, 1 bit each: decoded class of the instruction currently in the IR.
REQ-008 Port `branch_taken` SHALL be an input, 1 bit wide: the ALU compare result.
REQ-009 Port `dmem_req` SHALL be an output, 1 bit wide: the data memory request.
REQ-010 Port `dmem_we` SHALL be an output, 1 bit wide: the data memory write enable.
REQ-011 Port `dmem_ack` SHALL be an input, 1 bit wide: the data access is complete.
REQ-012 Port `pc_write` SHALL be an output, 1 bit wide: the PC update strobe.
REQ-013 Port `pc_sel` SHALL be an output, 1 bit wide: 0 selects pc+4 and 1 selects the computed target.
REQ-014 Port `rf_write` SHALL be an output, 1 bit wide: the register file write strobe.
REQ-015 Port `state` SHALL be an output, 3 bits wide: the current FSM state encoding.
REQ-016 Port `halted` SHALL be an output, 1 bit wide: the core is stopped.
REQ-017 Port `instret` SHALL be an output, 32 bits wide: the retired-instruction count.

Function
REQ-018 The FSM SHALL use these states: FETCH=0, DECODE=1, EXECUTE=2, MEM=3, WB=4, HALT=5; encodings 6 and 7 SHALL transition to HALT.
REQ-019 In FETCH, `imem_req` SHALL be 1, and `ir_write` SHALL equal `imem_ack`; on `imem_ack`=1 the next state SHALL be DECODE, otherwise the FSM SHALL stay in FETCH.
REQ-020 DECODE SHALL last one cycle; the next state SHALL be HALT if `illegal`, `is_system`, or (`is_load` and `is_store`) is 1, else EXECUTE.
REQ-021 EXECUTE SHALL last one cycle; the next state SHALL be MEM if `is_load` or `is_store` is 1, else WB.
REQ-022 In MEM, `dmem_req` SHALL be 1 and `dmem_we` SHALL equal `is_store`; both SHALL be held until the `dmem_ack` cycle inclusive, after which the next state SHALL be WB.
REQ-023 WB SHALL last one cycle with `pc_write`=1 and `pc_sel` = `is_jump` OR (`is_branch` AND `branch_taken`).
REQ-024 In WB, `rf_write` SHALL equal `reg_write_enable` AND NOT `is_store` AND NOT `is_branch`; `instret` SHALL increment by 1; the next state SHALL be FETCH.
REQ-025 HALT SHALL be absorbing until reset; in HALT, `halted` SHALL be 1 and all strobes and requests SHALL be 0.
REQ-026 The outputs `imem_req`, `ir_write`, `dmem_req`, `dmem_we`, `pc_write`, `pc_sel` and `rf_write` SHALL be combinational from state and inputs, and SHALL be 0 in every state not listed for them above.
REQ-027 `imem_ack` outside FETCH and `dmem_ack` outside MEM SHALL be ignored.
REQ-028 `instret` SHALL wrap from 0xFFFFFFFF to 0 without any side effect.
REQ-029 Latency: a non-memory instruction with an immediate `imem_ack` SHALL take 4 cycles (FETCH to WB inclusive); a load or store with immediate acknowledges SHALL take 5 cycles; each wait cycle SHALL add exactly 1 cycle.
REQ-030 The decoder inputs SHALL be sampled only in DECODE, EXECUTE, MEM and WB, and SHALL be assumed stable between consecutive `ir_write` pulses.

Reset
REQ-031 While `rst`=1, asynchronously, `state` SHALL be FETCH, `instret` SHALL be 0 and `halted` SHALL be 0.
REQ-032 Assertion of `rst` in mid-operation (including MEM with `dmem_req`=1) SHALL drop all requests and strobes within the same cycle.
REQ-033 After `rst` is released, the first `imem_req` SHALL be asserted in the first cycle.

Verification
REQ-034 ADDI with `imem_ack` tied to 1 -> states 0,1,2,4 repeat; `rf_write`=1 in WB; `instret` increments every 4 cycles.
REQ-035 Load with a 3-cycle `dmem_ack` delay -> MEM held for 3 cycles with `dmem_req`=1 and `dmem_we`=0; `rf_write`=1 in WB; total 7 cycles.
REQ-036 Store -> `dmem_we`=1 in MEM, `rf_write`=0 in WB; branch with `branch_taken`=1 -> `pc_sel`=1 and `rf_write`=0; branch with `branch_taken`=0 -> `pc_sel`=0.
REQ-037 `illegal`=1 in DECODE -> HALT next cycle with `halted`=1; a further `imem_ack` has no effect; `instret` is unchanged.
REQ-038 `instret` preset to 0xFFFFFFFF via 2^32-1 retirements (or force) plus one ADDI -> `instret`=0.
REQ-039 `rst` pulsed mid-MEM -> `dmem_req` drops in the same cycle, `state`=0, `instret`=0.
